text_mem_arbiter: RTL and testbench
===================================

// Module: text_mem_arbiter
// PURPOSE
//  Shares the single-port text/pattern RAM between N requesters, e.g. 0 = loader, 1 = search FSM, 2 = display reader.
//  Does round-robin arbitration with req/gnt handshake, optional locked bursts and a bounded hold for fairness.
//  Sits between the search control FSM / loader and the RAM; sequences every RAM access (1-cycle read latency).
// PARAMETERS
//  N_REQ     3   number of requesters (2..8)
//  ADDR_W    8   RAM address width
//  DATA_W    8   RAM data width
//  MAX_HOLD  16  max consecutive locked accesses while another requester waits (>=1)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               reset, synchronous, active-low
//  req        in   N_REQ           access request per requester
//  lock       in   N_REQ           keep grant for back-to-back accesses
//  we         in   N_REQ           1 = write, 0 = read
//  addr       in   N_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  wdata      in   N_REQ*DATA_W    packed write data, same packing
//  gnt        out  N_REQ           one-hot grant (registered)
//  rvalid     out  N_REQ           read data valid for requester i
//  rdata      out  DATA_W          read data, shared, qualified by rvalid
//  mem_en     out  1               RAM access strobe
//  mem_we     out  1               RAM write enable
//  mem_addr   out  ADDR_W          RAM address
//  mem_wdata  out  DATA_W          RAM write data
//  mem_rdata  in   DATA_W          RAM read data, valid 1 cycle after mem_en & !mem_we
//  busy       out  1               state != ST_IDLE
// BEHAVIOUR
//  Reset (rst==0 at clk edge) sets:
//   - state=ST_IDLE, ptr=0, owner=0, hold_cnt=0
//   - gnt=0, rvalid=0, busy=0; mem_en=0 (driven as 0 in ST_IDLE)
//   - any in-flight read is discarded: no rvalid after reset
//  ST_IDLE: gnt=0, mem_en=0.
//   - If |req: winner = first set req at or after ptr, wrapping mod N_REQ.
//   - Next: ST_OWN, owner=winner, hold_cnt=0.
//  ST_OWN: gnt[owner]=1.
//   - If req[owner]: mem_en=1; mem_we/addr/wdata muxed combinationally from owner; hold_cnt++.
//   - If req[owner]==0: no access (mem_en=0); go to ST_IDLE.
//   - Stay in ST_OWN iff req[owner] & lock[owner] & !(hold_cnt==MAX_HOLD-1 & others_req).
//   - Otherwise go to ST_IDLE and set ptr = (owner+1) mod N_REQ.
//   - others_req = |(req & ~onehot(owner)); a lone locked owner is never forced out.
//  Timing:
//   - unlocked access: req at t, gnt and access at t+1, IDLE at t+2; same requester re-granted at t+3 at earliest.
//   - locked burst: one access per cycle, no bubbles.
//   - handover between owners costs exactly one ST_IDLE cycle.
//  Read return: registered rd_pend/rd_owner; rvalid[rd_owner]=1 at t+1 for a read issued at t, rdata=mem_rdata.
//   - Delivered even if the grant has moved or state is ST_IDLE.
//  Requester rules: hold req/we/addr/wdata stable until sampled with gnt high. For a locked burst, change addr each gnt cycle.
//  Simultaneous events:
//   - req deasserted in the same cycle gnt rises: no access, return to ST_IDLE.
//   - lock without req is ignored.
//  hold_cnt width: $clog2(MAX_HOLD+1); saturates at MAX_HOLD; cleared on every grant.
// STRUCTURE
//  Package txt_pkg:
//   - arb_state_t enum {ST_IDLE, ST_OWN}
//   - default widths ADDR_W/DATA_W shared with the search datapath
//  Sub-module rr_picker: combinational (req, ptr) -> winner index + found flag.
//  One always_ff for state/ptr/owner/hold_cnt/rd_pend; always_comb for next-state and RAM mux.
// TESTING
//  1 Reset: rst=0 for 2 cycles with req=3'b111 -> gnt=0, mem_en=0, rvalid=0, busy=0; after release first gnt=3'b001.
//  2 Round-robin: req=3'b111, lock=0, held -> gnt sequence 001,000,010,000,100,000,001; each requester gets one access.
//  3 Read latency: req1 read addr=8'h2A, RAM[2A]=8'h5C -> gnt[1] at t+1, mem_addr=2A, rvalid[1]=1 and rdata=5C at t+2.
//  4 Locked burst and fairness (MAX_HOLD=4):
//    - req0+lock0 alone -> unbroken grants
//    - raise req2 mid-burst -> requester 0 gets exactly 4 accesses counted from its grant, then 1 idle cycle, then gnt=100
//  5 Write: req2 we=1 addr=10 wdata=77 -> single mem_en&mem_we cycle; later read by requester 0 of addr 10 returns 77.
//  6 Reset mid-read: assert rst the cycle after a read issues -> no rvalid, ptr=0, gnt=0.

Source files
------------

// File: rtl/txt_pkg.sv
// rtl/txt_pkg.sv - shared types and default widths for the text/pattern RAM path
package txt_pkg;

   // Default RAM geometry, shared with the search datapath.
   localparam int TXT_ADDR_W = 8;
   localparam int TXT_DATA_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/text_mem_arbiter_rr_picker.sv
// rtl/text_mem_arbiter_rr_picker.sv - combinational round-robin winner select
//  Ports:
//   req    in  N   request vector
//   ptr    in  W   highest-priority index for this pick
//   winner out W   first set req at or after ptr, wrapping mod N
//   found  out 1   any req set
module rr_picker #(
   parameter int N = 3,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] winner,
   output logic         found
);

   // Scan offsets from farthest to nearest so the nearest hit is the last
   // assignment and wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            winner = W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/text_mem_arbiter.sv
// rtl/text_mem_arbiter.sv - round-robin arbiter sharing the single-port text RAM
//  Ports:
//   clk, rst (sync, active-low)
//   req/lock/we [N_REQ], addr/wdata packed per requester
//   gnt [N_REQ] one-hot registered grant, rvalid [N_REQ], rdata shared
//   mem_en/mem_we/mem_addr/mem_wdata to RAM, mem_rdata from RAM (1-cycle latency)
//   busy = not idle
module text_mem_arbiter
   import txt_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = TXT_ADDR_W,
   parameter int DATA_W   = TXT_DATA_W,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         lock,
   input  logic [N_REQ-1:0]         we,
   input  logic [N_REQ*ADDR_W-1:0]  addr,
   input  logic [N_REQ*DATA_W-1:0]  wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int HC_W  = $clog2(MAX_HOLD + 1);

   arb_state_t       state, state_d;
   logic [PTR_W-1:0] ptr, ptr_d;
   logic [PTR_W-1:0] owner, owner_d;
   logic [PTR_W-1:0] owner_inc;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] rd_owner;
   logic [HC_W-1:0]  hold_cnt, hold_d;
   logic [N_REQ-1:0] owner_oh;
   logic [N_REQ-1:0] gnt_d;
   logic             found;
   logic             rd_pend;
   logic             others_req;
   logic             hold_limit;

   rr_picker #(
      .N (N_REQ),
      .W (PTR_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (winner),
      .found  (found)
   );

   assign owner_oh   = N_REQ'(1) << owner;
   assign others_req = |(req & ~owner_oh);
   assign hold_limit = (hold_cnt == HC_W'(MAX_HOLD - 1));
   assign owner_inc  = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

   // RAM side: the access strobe follows the live req of the owner so a
   // request dropped in the grant cycle produces no access.
   always_comb begin
      mem_en    = (state == ST_OWN) && req[owner];
      mem_we    = mem_en && we[owner];
      mem_addr  = addr[owner*ADDR_W +: ADDR_W];
      mem_wdata = wdata[owner*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      owner_d = owner;
      hold_d  = hold_cnt;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_OWN;
               owner_d = winner;
               hold_d  = '0;
            end
         end
         ST_OWN: begin
            if (req[owner] && hold_cnt != HC_W'(MAX_HOLD))
               hold_d = hold_cnt + 1'b1;
            // A lone locked owner keeps the RAM indefinitely; the hold limit
            // only bites while someone else is waiting.
            if (!(req[owner] && lock[owner] && !(hold_limit && others_req))) begin
               state_d = ST_IDLE;
               ptr_d   = owner_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      gnt_d = (state_d == ST_OWN) ? (N_REQ'(1) << owner_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         owner    <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         rd_pend  <= 1'b0;
         rd_owner <= '0;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         owner    <= owner_d;
         hold_cnt <= hold_d;
         gnt      <= gnt_d;
         // Read return is tracked independently of the grant so data still
         // reaches its requester after a handover or a drop to idle.
         rd_pend  <= mem_en && !mem_we;
         rd_owner <= owner;
      end
   end

   assign rvalid = rd_pend ? (N_REQ'(1) << rd_owner) : '0;
   assign rdata  = mem_rdata;
   assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_text_mem_arbiter.sv
// tb/tb_text_mem_arbiter.sv - directed self-checking bench for text_mem_arbiter
module tb_text_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, lock, we;
   logic [23:0] addr, wdata;
   logic [2:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   text_mem_arbiter #(
      .N_REQ(3), .ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model: unwritten locations read as addr ^ 8'h76 (so RAM[2A] = 5C).
   logic [7:0] ram [256];
   logic       written [256];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) written[i] <= 1'b0;
      end else if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h76);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req = 3'b000; lock = 3'b000; we = 3'b000;
      rst = 1'b0;
      tick; tick;
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; req = 3'b111; lock = 3'b000; we = 3'b000;
      addr = 24'h0; wdata = 24'h0;
      for (int c = 0; c < 2; c++) begin
         tick;
         n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt); end
         n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
         n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b want 000", rvalid); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      end
      rst = 1'b1;
      tick;
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_after: got %b want 1", busy); end
   endtask

   task automatic test_round_robin;
      logic [2:0] exp_gnt [7];
      logic [7:0] exp_adr [7];
      int acc [3];
      exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      exp_adr = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h01};
      acc = '{0, 0, 0};
      do_reset;
      addr = {8'h03, 8'h02, 8'h01};
      req = 3'b111;
      for (int i = 0; i < 7; i++) begin
         tick;
         n_checks++; if (gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
         n_checks++; if (mem_en !== (exp_gnt[i] != 3'b000)) begin n_fail++; $display("FAIL rr_mem_en[%0d]: got %b want %b", i, mem_en, exp_gnt[i] != 3'b000); end
         if (exp_gnt[i] != 3'b000) begin
            n_checks++; if (mem_addr !== exp_adr[i]) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", i, mem_addr, exp_adr[i]); end
         end
         if (i < 6) for (int k = 0; k < 3; k++) if (mem_en && gnt[k]) acc[k]++;
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (acc[k] != 1) begin n_fail++; $display("FAIL rr_access_count[%0d]: got %0d want 1", k, acc[k]); end
      end
      req = 3'b000;
      tick; tick;
   endtask

   task automatic test_read_latency;
      do_reset;
      addr = {8'h00, 8'h2A, 8'h00};
      req = 3'b010;
      tick;
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt: got %b want 010", gnt); end
      n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_strobe: got en=%b we=%b want en=1 we=0", mem_en, mem_we); end
      n_checks++; if (mem_addr !== 8'h2A) begin n_fail++; $display("FAIL rd_addr: got %h want 2a", mem_addr); end
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_rvalid_early: got %b want 000", rvalid); end
      tick;
      req = 3'b000;
      n_checks++; if (rvalid !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid: got %b want 010", rvalid); end
      n_checks++; if (rdata !== 8'h5C) begin n_fail++; $display("FAIL rd_rdata: got %h want 5c", rdata); end
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rd_gnt_idle: got %b want 000", gnt); end
      tick;
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_rvalid_once: got %b want 000", rvalid); end
   endtask

   task automatic test_locked_burst;
      logic [2:0] exp_gnt [6];
      // Lone locked owner: never forced out, even past MAX_HOLD.
      do_reset;
      req = 3'b001; lock = 3'b001;
      for (int i = 0; i < 7; i++) begin
         addr[7:0] = 8'h40 + 8'(i);
         tick;
         n_checks++; if (gnt !== 3'b001 || mem_en !== 1'b1) begin n_fail++; $display("FAIL lone_burst[%0d]: got gnt=%b en=%b want gnt=001 en=1", i, gnt, mem_en); end
      end
      n_checks++; if (mem_addr !== 8'h46) begin n_fail++; $display("FAIL lone_burst_addr: got %h want 46", mem_addr); end
      // Competing requester raised during access 2: owner gets exactly 4.
      do_reset;
      exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};
      req = 3'b001; lock = 3'b001;
      for (int i = 0; i < 6; i++) begin
         addr[7:0] = 8'h50 + 8'(i);
         tick;
         if (i == 1) req = 3'b101;
         n_checks++; if (gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
         n_checks++; if (mem_en !== (exp_gnt[i] != 3'b000)) begin n_fail++; $display("FAIL fair_mem_en[%0d]: got %b want %b", i, mem_en, exp_gnt[i] != 3'b000); end
      end
      req = 3'b000; lock = 3'b000;
      tick; tick;
   endtask

   task automatic test_write;
      do_reset;
      addr = {8'h10, 8'h00, 8'h00};
      wdata = {8'h77, 8'h00, 8'h00};
      req = 3'b100; we = 3'b100;
      tick;
      n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL wr_gnt: got %b want 100", gnt); end
      n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got en=%b we=%b want 1 1", mem_en, mem_we); end
      n_checks++; if (mem_addr !== 8'h10 || mem_wdata !== 8'h77) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 10/77", mem_addr, mem_wdata); end
      tick;
      req = 3'b000; we = 3'b000;
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL wr_single: got en=%b want 0", mem_en); end
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid); end
      tick;
      addr = {8'h00, 8'h00, 8'h10};
      req = 3'b001;
      tick;
      n_checks++; if (gnt !== 3'b001 || mem_addr !== 8'h10) begin n_fail++; $display("FAIL wr_readback_gnt: got gnt=%b addr=%h want 001/10", gnt, mem_addr); end
      tick;
      req = 3'b000;
      n_checks++; if (rvalid !== 3'b001) begin n_fail++; $display("FAIL wr_readback_rvalid: got %b want 001", rvalid); end
      n_checks++; if (rdata !== 8'h77) begin n_fail++; $display("FAIL wr_readback_data: got %h want 77", rdata); end
      tick;
   endtask

   task automatic test_reset_mid_read;
      do_reset;
      addr = {8'h00, 8'h2A, 8'h00};
      req = 3'b010;
      tick;
      n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got en=%b want 1", mem_en); end
      rst = 1'b0;
      tick;
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL mid_rvalid: got %b want 000", rvalid); end
      n_checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_gnt_busy: got %b/%b want 000/0", gnt, busy); end
      rst = 1'b1;
      req = 3'b110;
      tick;
      // ptr back at 0 makes requester 1 the winner; a stale ptr of 2 would pick 2.
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL mid_ptr: got gnt=%b want 010", gnt); end
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL mid_rvalid_late: got %b want 000", rvalid); end
      req = 3'b000;
      tick; tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_round_robin;
      test_read_latency;
      test_locked_burst;
      test_write;
      test_reset_mid_read;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
